// File: rtl/borus_out_uart.sv
// Change-detecting CPU output port to 8N1 UART with halt marker. A change sampled at edge k is
// queued at edge k and starts its frame at edge k+1. No backpressure: writes into a full FIFO are dropped and set a sticky overflow.
module borus_out_uart #(
  parameter int          CLKS_PER_BIT   = 16,
  parameter int          FIFO_DEPTH     = 8,
  parameter logic [7:0]  HALT_MARKER    = 8'hFF,
  parameter bit          HALT_MARKER_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    out_port,
  input  logic                          halted,
  input  logic                          clr_overflow,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CW   = AW + 1;
  localparam int CNTW = $clog2(CLKS_PER_BIT);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t            state;
  logic [7:0]        prev;
  logic              halted_d;
  logic              halt_pending;
  logic [7:0]        mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNTW-1:0]   clk_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shreg;

  logic              change;
  logic              wr_vld;
  logic [7:0]        wr_dat;
  logic              full;
  logic              push;
  logic              drop;
  logic              pop;
  logic              bit_end;
  logic              halt_rise;

  always_comb begin
    change    = (out_port != prev);
    // A change write always wins; a pending marker waits for a quiet cycle.
    wr_vld    = change | halt_pending;
    wr_dat    = change ? out_port : HALT_MARKER;
    full      = (fifo_count == CW'(FIFO_DEPTH));
    push      = wr_vld & ~full;
    drop      = wr_vld & full;
    pop       = (state == IDLE) && (fifo_count != '0);
    bit_end   = (clk_cnt == CNTW'(CLKS_PER_BIT - 1));
    halt_rise = HALT_MARKER_EN && halted && !halted_d;
  end

  assign busy = (state != IDLE) | (fifo_count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_dat;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev         <= 8'h00;
      halted_d     <= 1'b0;
      halt_pending <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      overflow     <= 1'b0;
    end else begin
      prev     <= out_port;
      halted_d <= halted;
      if (halt_pending && !change) halt_pending <= 1'b0;
      if (halt_rise)               halt_pending <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)              overflow <= 1'b1;
      else if (clr_overflow) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shreg   <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (pop) begin
            shreg   <= mem[rd_ptr];
            state   <= START;
            tx      <= 1'b0;
            clk_cnt <= '0;
          end
        end
        START: begin
          if (bit_end) begin
            state   <= DATA;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
            clk_cnt <= '0;
            bit_idx <= '0;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shreg[0];
              shreg   <= shreg >> 1;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: begin
          tx <= 1'b1;
          if (bit_end) state   <= IDLE;
          else         clk_cnt <= clk_cnt + 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_borus_out_uart.sv
// Directed bench for borus_out_uart; two instances (marker enabled / disabled) share stimulus.
module tb_borus_out_uart;

  localparam int CPB   = 4;
  localparam int DEPTH = 8;

  logic       clk;
  logic       rst;
  logic [7:0] out_port;
  logic       halted;
  logic       clr_overflow;
  logic       tx0, busy0, ovf0;
  logic       tx1, busy1, ovf1;
  logic [3:0] cnt0, cnt1;

  int vectors;
  int miscompares;
  int rx_cnt [2];
  int m_off [2];
  bit m_act [2];
  logic [7:0] m_byte [2];
  logic [7:0] exp_q0 [$];
  logic [7:0] exp_q1 [$];

  borus_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .HALT_MARKER(8'hFF), .HALT_MARKER_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .out_port(out_port), .halted(halted), .clr_overflow(clr_overflow),
    .tx(tx0), .busy(busy0), .fifo_count(cnt0), .overflow(ovf0));

  borus_out_uart #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH), .HALT_MARKER(8'hFF), .HALT_MARKER_EN(1'b0)) dut_nm (
    .clk(clk), .rst(rst), .out_port(out_port), .halted(halted), .clr_overflow(clr_overflow),
    .tx(tx1), .busy(busy1), .fifo_count(cnt1), .overflow(ovf1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Frame receiver: samples mid-bit on negedges, then pops the scoreboard.
  task automatic mon_step(input int d, input logic txv);
    int idx;
    logic [7:0] e;
    if (rst) begin
      m_act[d] = 1'b0;
    end else if (!m_act[d]) begin
      if (txv == 1'b0) begin
        m_act[d]  = 1'b1;
        m_off[d]  = 0;
        m_byte[d] = 8'h00;
      end
    end else begin
      m_off[d]++;
      if (m_off[d] == CPB / 2) check($sformatf("start_low%0d", d), txv, 1'b0);
      if (m_off[d] >= CPB && m_off[d] < CPB * 9 && (m_off[d] % CPB) == CPB / 2) begin
        idx = m_off[d] / CPB - 1;
        m_byte[d][idx[2:0]] = txv;
      end
      if (m_off[d] == CPB * 9 + CPB / 2) begin
        check($sformatf("stop_high%0d", d), txv, 1'b1);
        rx_cnt[d]++;
        m_act[d] = 1'b0;
        if (d == 0) begin
          check("frame_queued0", exp_q0.size() > 0, 1'b1);
          if (exp_q0.size() > 0) begin
            e = exp_q0.pop_front();
            check("frame_byte0", m_byte[0], e);
          end
        end else begin
          check("frame_queued1", exp_q1.size() > 0, 1'b1);
          if (exp_q1.size() > 0) begin
            e = exp_q1.pop_front();
            check("frame_byte1", m_byte[1], e);
          end
        end
      end
    end
  endtask

  always @(negedge clk) begin
    mon_step(0, tx0);
    mon_step(1, tx1);
  end

  task automatic push_both(input logic [7:0] v);
    exp_q0.push_back(v);
    exp_q1.push_back(v);
  endtask

  task automatic wait_idle(input string tag, input int max_cycles);
    int n;
    n = 0;
    while ((busy0 || busy1) && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, busy0 | busy1, 1'b0);
    check({tag, "_q0_empty"}, exp_q0.size(), 0);
    check({tag, "_q1_empty"}, exp_q1.size(), 0);
  endtask

  initial begin
    int rx0_b, rx1_b;
    vectors = 0;
    miscompares = 0;
    rx_cnt[0] = 0;
    rx_cnt[1] = 0;
    m_act[0] = 1'b0;
    m_act[1] = 1'b0;
    rst = 1'b1;
    out_port = 8'h00;
    halted = 1'b0;
    clr_overflow = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx", tx0, 1'b1);
    check("rst_busy", busy0, 1'b0);
    check("rst_count", cnt0, 4'd0);
    check("rst_ovf", ovf0, 1'b0);
    rst = 1'b0;

    // Held port after reset: line stays idle
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      check("hold_tx", tx0, 1'b1);
    end
    check("hold_count", cnt0, 4'd0);
    check("hold_busy", busy0, 1'b0);

    // Single change: exact frame timing
    @(negedge clk);
    out_port = 8'hA5;
    push_both(8'hA5);
    @(negedge clk);
    check("t1_tx_pre", tx0, 1'b1);
    check("t1_count", cnt0, 4'd1);
    @(negedge clk);
    check("t1_start", tx0, 1'b0);
    check("t1_count_pop", cnt0, 4'd0);
    check("t1_busy", busy0, 1'b1);
    repeat (39) @(negedge clk);
    check("t1_stop_tx", tx0, 1'b1);
    check("t1_stop_busy", busy0, 1'b1);
    @(negedge clk);
    check("t1_end_busy", busy0, 1'b0);
    repeat (20) @(negedge clk);
    check("t1_rx", rx_cnt[0], 1);
    wait_idle("t1", 200);

    // Burst of ten values: 10th dropped
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      out_port = i[7:0];
      if (i <= 9) push_both(i[7:0]);
    end
    @(negedge clk);
    check("t3_count0", cnt0, 4'd8);
    check("t3_count1", cnt1, 4'd8);
    check("t3_ovf0", ovf0, 1'b1);
    check("t3_ovf1", ovf1, 1'b1);
    wait_idle("t3", 2000);

    // Halt marker
    rx0_b = rx_cnt[0];
    rx1_b = rx_cnt[1];
    @(negedge clk);
    out_port = 8'h07;
    push_both(8'h07);
    exp_q0.push_back(8'hFF);
    @(negedge clk);
    halted = 1'b1;
    repeat (3) @(negedge clk);
    wait_idle("t4", 500);
    check("t4_frames0", rx_cnt[0] - rx0_b, 2);
    check("t4_frames1", rx_cnt[1] - rx1_b, 1);
    halted = 1'b0;

    // Reset mid-frame with three bytes queued
    rx0_b = rx_cnt[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      out_port = 8'h31 + i[7:0];
      push_both(8'h31 + i[7:0]);
    end
    repeat (8) @(negedge clk);
    check("t5_queued", cnt0, 4'd3);
    @(posedge clk);
    #1;
    rst = 1'b1;
    out_port = 8'h00;
    exp_q0.delete();
    exp_q1.delete();
    #1;
    check("t5_rst_tx", tx0, 1'b1);
    check("t5_rst_count", cnt0, 4'd0);
    check("t5_rst_busy", busy0, 1'b0);
    check("t5_rst_ovf", ovf0, 1'b0);
    repeat (3) @(negedge clk);
    check("t5_rst_tx_hold", tx0, 1'b1);
    rst = 1'b0;
    repeat (100) @(negedge clk);
    check("t5_post_busy", busy0, 1'b0);
    check("t5_post_tx", tx0, 1'b1);
    check("t5_post_rx", rx_cnt[0], rx0_b);

    // Overflow set beats a coincident clear
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      out_port = 8'h10 + i[7:0];
      if (i <= 9) push_both(8'h10 + i[7:0]);
      clr_overflow = (i == 10);
    end
    @(negedge clk);
    clr_overflow = 1'b0;
    check("t6_ovf_set", ovf0, 1'b1);
    check("t6_ovf_set_nm", ovf1, 1'b1);
    check("t6_count", cnt0, 4'd8);
    @(negedge clk);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    check("t6_ovf_clr", ovf0, 1'b0);
    check("t6_ovf_clr_nm", ovf1, 1'b0);
    wait_idle("t6", 2000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/borus_out_uart.md
Name: borus_out_uart

Overview:
- Downstream consumer of the BorusCPU core's 8-bit output port and halted flag.
- Watches the output port for value changes and queues each new value in a small FIFO.
- Serialises queued bytes as 8N1 UART frames on a single tx line.
- On the halted rising edge, optionally queues a halt marker byte so a host sees program end.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per UART bit; must be >= 2.
- FIFO_DEPTH, 8, FIFO entries; must be a power of 2, >= 2.
- HALT_MARKER, 8'hFF, byte queued on the halted rising edge.
- HALT_MARKER_EN, 1, 1 = queue HALT_MARKER on the halted rising edge; 0 = no marker.

Ports:
- clk  input  1  system clock (same clock as the CPU core)
- rst  input  1  reset, asynchronous, active-high
- out_port  input  8  CPU output port value
- halted  input  1  CPU halted flag
- clr_overflow  input  1  synchronous clear of the overflow flag
- tx  output  1  UART serial out; idle high
- busy  output  1  high while the FIFO is non-empty or a frame is in progress
- fifo_count  output  $clog2(FIFO_DEPTH)+1  number of queued bytes
- overflow  output  1  sticky; set when a byte is dropped because the FIFO is full

Behaviour:
- Reset is asynchronous, active-high; clock is clk.
- Reset values: tx=1, busy=0, fifo_count=0, overflow=0. Internal: shadow prev=8'h00, halted_d=0, halt_pending=0, FSM=IDLE.
- Change detect:
  - At each clk edge, if out_port != prev, write out_port to the FIFO.
  - prev <= out_port every cycle.
  - A held value produces exactly one write.
- Halt marker:
  - If HALT_MARKER_EN=1 and halted & !halted_d, set halt_pending.
  - halt_pending writes HALT_MARKER on the first edge with no change-detect write, then clears.
  - halted_d <= halted every cycle.
  - At most one FIFO write per cycle; a change write has priority over the marker.
- FIFO full:
  - A write is dropped when fifo_count == FIFO_DEPTH, evaluated before any same-cycle pop.
  - A drop sets overflow.
  - clr_overflow clears overflow; if a drop and clr_overflow occur in the same cycle, set wins.
- FIFO order: strict FIFO. Read and write pointers wrap modulo FIFO_DEPTH.
- UART FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If fifo_count != 0, pop the head into the shift register and go to START at that edge.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. A 3-bit bit index ends at 7, then STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
  - Back-to-back frames are separated by exactly one IDLE cycle.
- Latency: a change sampled at edge k is written at edge k, popped at edge k+1, and tx falls after edge k+1.
- Frame length: 10*CLKS_PER_BIT cycles.
- tx is registered; no glitches.
- busy = (FSM != IDLE) | (fifo_count != 0), combinational from registers.
- Simultaneous push and pop: fifo_count is unchanged.
- Reset mid-frame: tx returns to 1 immediately, the FIFO is emptied, and the frame in progress is abandoned.
- The bench must drive out_port to defined values from reset release onward; the CPU core does not reset out_port.

Test Plan (CLKS_PER_BIT=4, FIFO_DEPTH=8):
1. out_port 8'h00 -> 8'hA5, then held → one frame: tx low 4 clk starting 2 clk after the change, then bits 1,0,1,0,0,1,0,1 at 4 clk each, stop high 4 clk; busy drops after stop; no second frame.
2. out_port held at 8'h00 for 200 cycles after reset → tx stays 1, fifo_count=0, busy=0.
3. Ten distinct values, one per clk from an idle state → fifo_count peaks at 8; the 10th value is dropped; overflow=1; frames carry values 1..9 in order.
4. out_port 8'h07, then halted 0->1 on the next cycle → frames 8'h07, then 8'hFF; with HALT_MARKER_EN=0, only 8'h07.
5. Assert rst mid-way through DATA of a frame, with 3 bytes queued → tx=1, fifo_count=0, busy=0 while rst is high; no frame after release until out_port changes.
6. Overflow condition coinciding with clr_overflow=1 → overflow stays 1; clr_overflow alone in a later cycle → overflow=0.
